e_mdu_ctrl: RTL and testbench

E_MDU_CTRL -- requirements
Module: e_mdu_ctrl

---
 rtl/e_mdu_ctrl_pkg.sv | 48 ++++
 rtl/e_mdu_ctrl_if.sv | 23 ++
 rtl/e_mdu_calc.sv | 60 ++++++
 rtl/e_mdu_ctrl.sv | 100 ++++++++++
 tb/tb_e_mdu_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/e_mdu_ctrl_pkg.sv
// Shared E-stage CPU definitions: ALU and MDU operation codes plus MDU timing defaults.
package e_mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluNor  = 4'd5,
    AluSlt  = 4'd6,
    AluSltu = 4'd7,
    AluSll  = 4'd8,
    AluSrl  = 4'd9,
    AluSra  = 4'd10,
    AluLui  = 4'd11
  } alu_op_e;

  // Codes 9..15 are unassigned and decode as MduNone.
  typedef enum logic [3:0] {
    MduNone  = 4'd0,
    MduMult  = 4'd1,
    MduMultu = 4'd2,
    MduDiv   = 4'd3,
    MduDivu  = 4'd4,
    MduMthi  = 4'd5,
    MduMtlo  = 4'd6,
    MduMfhi  = 4'd7,
    MduMflo  = 4'd8
  } mdu_op_e;

  localparam int unsigned MultCyclesDef = 5;
  localparam int unsigned DivCyclesDef  = 10;

  function automatic logic is_mult_op(mdu_op_e op);
    return (op == MduMult) || (op == MduMultu);
  endfunction

  function automatic logic is_div_op(mdu_op_e op);
    return (op == MduDiv) || (op == MduDivu);
  endfunction

  // Ops that occupy the unit for a multi-cycle busy period.
  function automatic logic is_long_op(mdu_op_e op);
    return is_mult_op(op) || is_div_op(op);
  endfunction

endpackage

// File: rtl/e_mdu_ctrl_if.sv
// E-stage MDU request/response bundle between the pipeline and the MDU controller.
interface e_mdu_ctrl_if;
  import e_mdu_ctrl_pkg::*;

  mdu_op_e     MDUOp_E;
  logic [31:0] SrcA_E;
  logic [31:0] SrcB_E;
  logic        Start_E;
  logic        Busy_E;
  logic [31:0] MDUResult_E;
  logic        StallReq_E;

  modport master (
    output MDUOp_E, SrcA_E, SrcB_E, Start_E,
    input  Busy_E, MDUResult_E, StallReq_E
  );

  modport slave (
    input  MDUOp_E, SrcA_E, SrcB_E, Start_E,
    output Busy_E, MDUResult_E, StallReq_E
  );

endinterface

// File: rtl/e_mdu_calc.sv
// Combinational MDU arithmetic: 64-bit {HI,LO} result for MULT/MULTU/DIV/DIVU.
module e_mdu_calc
  import e_mdu_ctrl_pkg::*;
(
  input  mdu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] result_o,
  output logic        valid_o    // low when the op must not update HI/LO
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               b_nz;
  logic signed [32:0] sa, sb, sq, sr;
  logic        [31:0] ub, uq, ur;

  assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Divisor forced to 1 on divide-by-zero so the dividers never see zero; result is discarded.
  assign b_nz = |b_i;
  assign ub   = b_nz ? b_i : 32'd1;
  // 33-bit signed divide makes 0x80000000 / -1 yield +2^31, whose low word is 0x80000000.
  assign sa   = $signed({a_i[31], a_i});
  assign sb   = b_nz ? $signed({b_i[31], b_i}) : 33'sd1;
  assign sq   = sa / sb;
  assign sr   = sa % sb;
  assign uq   = a_i / ub;
  assign ur   = a_i % ub;

  // Select result by operation; {HI,LO} = {remainder, quotient} for divides.
  always_comb begin
    result_o = 64'd0;
    valid_o  = 1'b0;
    case (op_i)
      MduMult: begin
        result_o = prod_s;
        valid_o  = 1'b1;
      end
      MduMultu: begin
        result_o = prod_u;
        valid_o  = 1'b1;
      end
      MduDiv: begin
        result_o = {sr[31:0], sq[31:0]};
        valid_o  = b_nz;
      end
      MduDivu: begin
        result_o = {ur, uq};
        valid_o  = b_nz;
      end
      default: begin
        result_o = 64'd0;
        valid_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide controller: sequences busy periods and owns the HI/LO registers.
module e_mdu_ctrl
  import e_mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDef,
  parameter int unsigned DIV_CYCLES  = DivCyclesDef
) (
  input logic          clk,
  input logic          reset,
  e_mdu_ctrl_if.slave  mdu
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [63:0]       pend_q, pend_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  logic [63:0]       calc_result;
  logic              calc_valid;
  logic              long_start;

  e_mdu_calc u_calc (
    .op_i     (mdu.MDUOp_E),
    .a_i      (mdu.SrcA_E),
    .b_i      (mdu.SrcB_E),
    .result_o (calc_result),
    .valid_o  (calc_valid)
  );

  assign long_start = mdu.Start_E && is_long_op(mdu.MDUOp_E);

  // State, counter, pending result and HI/LO registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state logic: launch in IDLE, count down in RUN, commit on the last busy cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (long_start) begin
          // A discarded result (divide by zero) latches current HI/LO so the commit is a no-op.
          pend_d  = calc_valid ? calc_result : {hi_q, lo_q};
          cnt_d   = is_mult_op(mdu.MDUOp_E) ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
          state_d = StRun;
        end else if (mdu.Start_E && (mdu.MDUOp_E == MduMthi)) begin
          hi_d = mdu.SrcA_E;
        end else if (mdu.Start_E && (mdu.MDUOp_E == MduMtlo)) begin
          lo_d = mdu.SrcA_E;
        end
      end
      StRun: begin
        // Start_E is ignored here; the hazard unit keeps it low while busy.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q <= CntW'(1)) begin
          hi_d    = pend_q[63:32];
          lo_d    = pend_q[31:0];
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: busy/stall flags and MFHI/MFLO read mux from committed HI/LO.
  always_comb begin
    mdu.Busy_E      = (state_q == StRun);
    mdu.StallReq_E  = (state_q == StRun) || long_start;
    mdu.MDUResult_E = 32'd0;
    case (mdu.MDUOp_E)
      MduMfhi: mdu.MDUResult_E = hi_q;
      MduMflo: mdu.MDUResult_E = lo_q;
      default: mdu.MDUResult_E = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Self-checking bench for e_mdu_ctrl: vector table plus reset/ignored-start sequences.
module tb_e_mdu_ctrl;
  import e_mdu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  e_mdu_ctrl_if mif ();

  e_mdu_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mif)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] op, logic start, logic [31:0] a, logic [31:0] b,
                              int cyc, logic [31:0] hi, logic [31:0] lo);
    vec_t v;
    v.op = op; v.start = start; v.a = a; v.b = b; v.cyc = cyc; v.hi = hi; v.lo = lo;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic start, input logic [31:0] a,
                       input logic [31:0] b);
    mif.MDUOp_E = mdu_op_e'(op);
    mif.Start_E = start;
    mif.SrcA_E  = a;
    mif.SrcB_E  = b;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    mif.MDUOp_E = MduMfhi;
    #1 check({tag, " MFHI"}, mif.MDUResult_E, hi);
    mif.MDUOp_E = MduMflo;
    #1 check({tag, " MFLO"}, mif.MDUResult_E, lo);
    mif.MDUOp_E = MduNone;
  endtask

  initial begin
    int n;
    logic stall_ok;

    // op, start, a, b, busy cycles, HI, LO (expected after the op, chained in order)
    tbl.push_back(mk(4'd1, 1, 32'hFFFFFFFE, 32'h00000003, 5,  32'hFFFFFFFF, 32'hFFFFFFFA));
    tbl.push_back(mk(4'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001));
    tbl.push_back(mk(4'd1, 1, 32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000));
    tbl.push_back(mk(4'd2, 1, 32'h80000000, 32'h00000002, 5,  32'h00000001, 32'h00000000));
    tbl.push_back(mk(4'd1, 1, 32'h00000007, 32'h00000006, 5,  32'h00000000, 32'h0000002A));
    tbl.push_back(mk(4'd3, 1, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD));
    tbl.push_back(mk(4'd4, 1, 32'hFFFFFFF9, 32'h00000002, 10, 32'h00000001, 32'h7FFFFFFC));
    tbl.push_back(mk(4'd3, 1, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000));
    tbl.push_back(mk(4'd3, 1, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD));
    tbl.push_back(mk(4'd4, 1, 32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E));
    tbl.push_back(mk(4'd5, 1, 32'h12345678, 32'h0,        0,  32'h12345678, 32'h0000000E));
    tbl.push_back(mk(4'd6, 1, 32'h9ABCDEF0, 32'h0,        0,  32'h12345678, 32'h9ABCDEF0));
    tbl.push_back(mk(4'd4, 1, 32'h00000005, 32'h0,        10, 32'h12345678, 32'h9ABCDEF0));
    tbl.push_back(mk(4'd3, 1, 32'h00000005, 32'h0,        10, 32'h12345678, 32'h9ABCDEF0));
    tbl.push_back(mk(4'd1, 0, 32'h00000003, 32'h3,        0,  32'h12345678, 32'h9ABCDEF0));
    tbl.push_back(mk(4'd9, 1, 32'h00000003, 32'h3,        0,  32'h12345678, 32'h9ABCDEF0));
    tbl.push_back(mk(4'd15, 1, 32'h00000003, 32'h3,       0,  32'h12345678, 32'h9ABCDEF0));
    tbl.push_back(mk(4'd7, 1, 32'h00000003, 32'h3,        0,  32'h12345678, 32'h9ABCDEF0));
    tbl.push_back(mk(4'd6, 0, 32'h00000001, 32'h0,        0,  32'h12345678, 32'h9ABCDEF0));

    drive(4'd0, 0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst Busy_E", {31'd0, mif.Busy_E}, 32'd0);
    check("rst StallReq_E", {31'd0, mif.StallReq_E}, 32'd0);
    read_hilo("rst", 32'd0, 32'd0);

    // Vector table
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].op, tbl[i].start, tbl[i].a, tbl[i].b);
      #1 check($sformatf("v%0d stall at start", i), {31'd0, mif.StallReq_E},
               {31'd0, tbl[i].cyc != 0});
      @(negedge clk);
      drive(4'd0, 0, 32'd0, 32'd0);
      n = 0;
      stall_ok = 1'b1;
      while (mif.Busy_E && n < 30) begin
        if (!mif.StallReq_E) stall_ok = 1'b0;
        n++;
        @(negedge clk);
      end
      check($sformatf("v%0d busy cycles", i), n, tbl[i].cyc);
      check($sformatf("v%0d stall while busy", i), {31'd0, stall_ok}, 32'd1);
      check($sformatf("v%0d stall after", i), {31'd0, mif.StallReq_E}, 32'd0);
      read_hilo($sformatf("v%0d", i), tbl[i].hi, tbl[i].lo);
    end

    // Start during RUN is ignored; MFLO during RUN returns the old LO
    @(negedge clk);
    drive(4'd6, 1, 32'h11111111, 32'd0);
    @(negedge clk);
    drive(4'd1, 1, 32'h00000003, 32'h00000005);
    @(negedge clk);
    check("ign busy1", {31'd0, mif.Busy_E}, 32'd1);
    drive(4'd8, 0, 32'd0, 32'd0);
    #1 check("ign MFLO busy1", mif.MDUResult_E, 32'h11111111);
    @(negedge clk);
    drive(4'd6, 1, 32'hDEADBEEF, 32'd0);
    @(negedge clk);
    drive(4'd8, 0, 32'd0, 32'd0);
    #1 check("ign MFLO busy3", mif.MDUResult_E, 32'h11111111);
    n = 2;
    while (mif.Busy_E && n < 30) begin
      n++;
      @(negedge clk);
    end
    check("ign busy cycles", n, 5);
    read_hilo("ign", 32'h00000000, 32'h0000000F);

    // Reset during RUN aborts with no commit
    @(negedge clk);
    drive(4'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    drive(4'd0, 0, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("abort busy3", {31'd0, mif.Busy_E}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy after", {31'd0, mif.Busy_E}, 32'd0);
    read_hilo("abort", 32'd0, 32'd0);
    repeat (12) @(negedge clk);
    check("abort busy later", {31'd0, mif.Busy_E}, 32'd0);
    read_hilo("abort later", 32'd0, 32'd0);

    // Reset coincident with Start takes priority
    @(negedge clk);
    drive(4'd6, 1, 32'h55555555, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(4'd1, 1, 32'h00000003, 32'h00000005);
    @(negedge clk);
    reset = 1'b0;
    drive(4'd0, 0, 32'd0, 32'd0);
    check("rststart busy", {31'd0, mif.Busy_E}, 32'd0);
    repeat (8) @(negedge clk);
    check("rststart busy later", {31'd0, mif.Busy_E}, 32'd0);
    read_hilo("rststart", 32'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
